pulse_emulator: RTL and testbench
=================================

Name: pulse_emulator

Overview:
- Synthetic ADC source that drives the same 4-channel, 2-samples-per-clock interface the trigger generator consumes (adc_data_x[31:0] = {sample1, sample0}, signed 16-bit each).
- On a start command it emits a programmable baseline on all channels, then rectangular pulses on channels a, b and c in sequence, with programmable width and start-to-start delays.
- Used in loopback/bench builds to exercise the trigger chain and its time-of-flight output without real probes.

Parameters:
- ADC_DATA_WIDTH, 16, width of one sample.
- WAIT_WIDTH, 32, width of the width, delay and elapsed counters.

Ports:
- rxclk  in  1  sample clock, 125 MHz.
- rstn  in  1  asynchronous active-low reset.
- emu_enable  in  1  0 = abort and idle; 1 = allow runs.
- start  in  1  level; sampled in IDLE only.
- baseline  in  16  signed baseline sample value.
- amp_a, amp_b, amp_c  in  16 each  signed pulse amplitude added to the baseline.
- pulse_width  in  WAIT_WIDTH  pulse length in clocks; 0 is treated as 1.
- delay_ab  in  WAIT_WIDTH  clocks from pulse A start to pulse B start.
- delay_bc  in  WAIT_WIDTH  clocks from pulse B start to pulse C start.
- adc_data_a/b/c/d  out  32 each  {sample1, sample0}.
- adc_valid_a/b/c/d  out  1 each  data valid.
- adc_enable_a/b/c/d  out  1 each  channel enabled.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- expected_tof  out  32  latched delay_ab, in clocks.

Behaviour:
- Reset (rstn=0, async):
  - all adc_data = 0; valid = 0; enable = 0.
  - busy = 0; done = 0; expected_tof = 0; state = IDLE.
- All outputs are registered.
- adc_enable_x = emu_enable, registered.
- adc_valid_x = emu_enable, registered; one sample pair is emitted every clock.
- Channel d always carries {baseline, baseline}.
- Non-pulsing channels carry {baseline, baseline}.
- Pulse value = sat16(baseline + amp_x), computed as a 17-bit signed sum and clamped to [0x8000, 0x7FFF]. Both halves of the word are equal.
- States:
  - IDLE → PULSE_A when emu_enable & start.
  - PULSE_A → GAP_AB → PULSE_B → GAP_BC → PULSE_C → DONE.
  - DONE → IDLE when start = 0 (start must drop before the next run).
- Shadow registers:
  - On the IDLE→PULSE_A transition, latch baseline, amps, pulse_width, delay_ab and delay_bc.
  - Input changes mid-run have no effect.
  - On the same transition, set expected_tof = delay_ab, busy = 1, done = 0.
- Timing, with start sampled high in IDLE at cycle T and W = max(pulse_width, 1):
  - Channel a pulses during T+1 .. T+W.
  - Channel b pulses from T+1+Dab for W clocks, where Dab = max(delay_ab, W); pulses never overlap.
  - Channel c pulses from its B start + Dbc for W clocks, where Dbc = max(delay_bc, W).
- One elapsed counter is used, reset at each pulse start. Gap states compare it against the latched delay.
- On entry to DONE: busy = 0, done = 1. done holds until the next run starts or until emu_enable = 0.
- emu_enable = 0 at any time:
  - next clock: state = IDLE, busy = 0, done = 0, all data back to baseline, valid and enable = 0.
  - This is not an error.
- start high while busy is ignored.
- start held high through DONE does not retrigger.
- Counter wrap is not possible: a gap ends at most at 2^WAIT_WIDTH − 1 clocks.
- Reset mid-run: immediate return to the reset values above.

Decomposition:
- Shared package pulse_emu_pkg:
  - state encoding localparams (3-bit, Gray-ordered as in the trigger FSM);
  - SAMPLE_MAX = 16'sh7FFF and SAMPLE_MIN = 16'sh8000;
  - the word-packing helper {s, s}.
- One sub-module, pulse_emu_sat_add: combinational signed 16+16 → saturated 16. It is instanced three times (a, b, c).

Test Plan:
- Basic run: baseline = 0x0000, amp_a/b/c = 0x1000, width = 4, delay_ab = 100, delay_bc = 50, start at T → adc_data_a = 0x10001000 for T+1..T+4; b for T+101..T+104; c for T+151..T+154; done = 1 at T+155; expected_tof = 100.
- Saturation: baseline = 0x7000, amp_a = 0x2000 → 0x7FFF7FFF. Baseline = 0x9000, amp_b = 0xE000 → 0x80008000. Channel d stays at 0x70007000 (first case) and 0x90009000 (second case).
- Clamping: width = 0, delay_ab = 0, delay_bc = 2 → each pulse lasts 1 clock; starts at T+1, T+2, T+4.
- Abort: emu_enable dropped during GAP_AB → next clock busy = 0, done = 0, valid = 0; channel b never pulses. Re-enable and start → full run occurs.
- Retrigger and shadowing:
  - start held high for the whole run → exactly one sequence; a new run only after start drops and rises again.
  - delay_ab changed mid-run → timing and expected_tof use the value latched at start.
- Async reset asserted during PULSE_B, mid-clock → all outputs 0 immediately; after release, state = IDLE and no pulse until the next start.

Source files
------------

// File: rtl/pulse_emu_pkg.sv
// Shared types and helpers for the synthetic ADC pulse source.
package pulse_emu_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

    // Gray-ordered so consecutive run states differ by one bit
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_PULSE_A = 3'b001,
        ST_GAP_AB  = 3'b011,
        ST_PULSE_B = 3'b010,
        ST_GAP_BC  = 3'b110,
        ST_PULSE_C = 3'b111,
        ST_DONE    = 3'b101
    } emu_state_t;

    function automatic logic [2*SAMPLE_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] s);
        return {s, s};
    endfunction

endpackage

// File: rtl/pulse_emu_sat_add.sv
// Signed 16+16 add with clamping to the representable sample range.
module pulse_emu_sat_add
    import pulse_emu_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    output logic signed [SAMPLE_W-1:0] sum
);

    logic signed [SAMPLE_W:0] wide;

    assign wide = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};

    // Top two bits disagree only on overflow; the sign bit tells which way
    always_comb begin
        case (wide[SAMPLE_W:SAMPLE_W-1])
            2'b01:   sum = SAMPLE_MAX;
            2'b10:   sum = SAMPLE_MIN;
            default: sum = wide[SAMPLE_W-1:0];
        endcase
    end

endmodule

// File: rtl/pulse_emulator.sv
// Synthetic 4-channel ADC source: baseline on all channels plus timed
// rectangular pulses on a, b, c for exercising the trigger chain.
module pulse_emulator
    import pulse_emu_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int WAIT_WIDTH     = 32
) (
    input  logic                             rxclk,
    input  logic                             rstn,
    input  logic                             emu_enable,
    input  logic                             start,
    input  logic signed [ADC_DATA_WIDTH-1:0] baseline,
    input  logic signed [ADC_DATA_WIDTH-1:0] amp_a,
    input  logic signed [ADC_DATA_WIDTH-1:0] amp_b,
    input  logic signed [ADC_DATA_WIDTH-1:0] amp_c,
    input  logic [WAIT_WIDTH-1:0]            pulse_width,
    input  logic [WAIT_WIDTH-1:0]            delay_ab,
    input  logic [WAIT_WIDTH-1:0]            delay_bc,
    output logic [2*ADC_DATA_WIDTH-1:0]      adc_data_a,
    output logic [2*ADC_DATA_WIDTH-1:0]      adc_data_b,
    output logic [2*ADC_DATA_WIDTH-1:0]      adc_data_c,
    output logic [2*ADC_DATA_WIDTH-1:0]      adc_data_d,
    output logic                             adc_valid_a,
    output logic                             adc_valid_b,
    output logic                             adc_valid_c,
    output logic                             adc_valid_d,
    output logic                             adc_enable_a,
    output logic                             adc_enable_b,
    output logic                             adc_enable_c,
    output logic                             adc_enable_d,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      expected_tof
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_ONE = WAIT_WIDTH'(1);

    emu_state_t                       state_reg, state_next;
    logic [WAIT_WIDTH-1:0]            elapsed_reg, elapsed_next;
    logic signed [ADC_DATA_WIDTH-1:0] base_reg;
    logic signed [ADC_DATA_WIDTH-1:0] amp_reg [3];
    logic [WAIT_WIDTH-1:0]            width_reg, dab_reg, dbc_reg;

    logic [WAIT_WIDTH-1:0]            width_eff, dab_eff, dbc_eff;
    logic                             start_run, last_pulse_clk, in_run_next;
    logic signed [ADC_DATA_WIDTH-1:0] amp_in    [3];
    logic signed [ADC_DATA_WIDTH-1:0] run_amp   [3];
    logic signed [ADC_DATA_WIDTH-1:0] pulse_val [3];
    logic signed [ADC_DATA_WIDTH-1:0] run_base, out_base;

    // Zero width means one clock; delays shorter than a pulse would overlap
    assign width_eff = (width_reg == '0) ? WAIT_ONE : width_reg;
    assign dab_eff   = (dab_reg < width_eff) ? width_eff : dab_reg;
    assign dbc_eff   = (dbc_reg < width_eff) ? width_eff : dbc_reg;

    assign start_run      = (state_reg == ST_IDLE) && emu_enable && start;
    assign last_pulse_clk = (elapsed_reg == width_eff - WAIT_ONE);

    always_comb begin
        state_next   = state_reg;
        elapsed_next = elapsed_reg + WAIT_ONE;
        if (!emu_enable) begin
            state_next   = ST_IDLE;
            elapsed_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    elapsed_next = '0;
                    if (start) state_next = ST_PULSE_A;
                end
                ST_PULSE_A: begin
                    if (last_pulse_clk) begin
                        if (dab_eff == width_eff) begin
                            state_next   = ST_PULSE_B;
                            elapsed_next = '0;
                        end else begin
                            state_next = ST_GAP_AB;
                        end
                    end
                end
                ST_GAP_AB: begin
                    if (elapsed_reg == dab_eff - WAIT_ONE) begin
                        state_next   = ST_PULSE_B;
                        elapsed_next = '0;
                    end
                end
                ST_PULSE_B: begin
                    if (last_pulse_clk) begin
                        if (dbc_eff == width_eff) begin
                            state_next   = ST_PULSE_C;
                            elapsed_next = '0;
                        end else begin
                            state_next = ST_GAP_BC;
                        end
                    end
                end
                ST_GAP_BC: begin
                    if (elapsed_reg == dbc_eff - WAIT_ONE) begin
                        state_next   = ST_PULSE_C;
                        elapsed_next = '0;
                    end
                end
                ST_PULSE_C: begin
                    if (last_pulse_clk) begin
                        state_next   = ST_DONE;
                        elapsed_next = '0;
                    end
                end
                ST_DONE: begin
                    elapsed_next = '0;
                    if (!start) state_next = ST_IDLE;
                end
                default: begin
                    state_next   = ST_IDLE;
                    elapsed_next = '0;
                end
            endcase
        end
    end

    assign in_run_next = (state_next == ST_PULSE_A) || (state_next == ST_GAP_AB) ||
                         (state_next == ST_PULSE_B) || (state_next == ST_GAP_BC) ||
                         (state_next == ST_PULSE_C);

    assign amp_in[0] = amp_a;
    assign amp_in[1] = amp_b;
    assign amp_in[2] = amp_c;

    // On the start clock the shadows are not loaded yet, so use the live inputs
    assign run_base = start_run ? baseline : base_reg;
    assign out_base = in_run_next ? run_base : baseline;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign run_amp[gi] = start_run ? amp_in[gi] : amp_reg[gi];

            pulse_emu_sat_add u_sat_add (
                .a   (run_base),
                .b   (run_amp[gi]),
                .sum (pulse_val[gi])
            );
        end
    endgenerate

    always_ff @(posedge rxclk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            elapsed_reg  <= '0;
            base_reg     <= '0;
            amp_reg[0]   <= '0;
            amp_reg[1]   <= '0;
            amp_reg[2]   <= '0;
            width_reg    <= '0;
            dab_reg      <= '0;
            dbc_reg      <= '0;
            adc_data_a   <= '0;
            adc_data_b   <= '0;
            adc_data_c   <= '0;
            adc_data_d   <= '0;
            adc_valid_a  <= 1'b0;
            adc_valid_b  <= 1'b0;
            adc_valid_c  <= 1'b0;
            adc_valid_d  <= 1'b0;
            adc_enable_a <= 1'b0;
            adc_enable_b <= 1'b0;
            adc_enable_c <= 1'b0;
            adc_enable_d <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            expected_tof <= '0;
        end else begin
            state_reg   <= state_next;
            elapsed_reg <= elapsed_next;
            if (start_run) begin
                base_reg     <= baseline;
                amp_reg[0]   <= amp_a;
                amp_reg[1]   <= amp_b;
                amp_reg[2]   <= amp_c;
                width_reg    <= pulse_width;
                dab_reg      <= delay_ab;
                dbc_reg      <= delay_bc;
                expected_tof <= 32'(delay_ab);
            end
            adc_data_a   <= pack_pair((state_next == ST_PULSE_A) ? pulse_val[0] : out_base);
            adc_data_b   <= pack_pair((state_next == ST_PULSE_B) ? pulse_val[1] : out_base);
            adc_data_c   <= pack_pair((state_next == ST_PULSE_C) ? pulse_val[2] : out_base);
            adc_data_d   <= pack_pair(out_base);
            adc_valid_a  <= emu_enable;
            adc_valid_b  <= emu_enable;
            adc_valid_c  <= emu_enable;
            adc_valid_d  <= emu_enable;
            adc_enable_a <= emu_enable;
            adc_enable_b <= emu_enable;
            adc_enable_c <= emu_enable;
            adc_enable_d <= emu_enable;
            busy         <= in_run_next;
            if (!emu_enable || start_run) begin
                done <= 1'b0;
            end else if (state_next == ST_DONE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_emulator.sv
// Randomized bench for pulse_emulator against a timeline model of each run.
module tb_pulse_emulator;

    logic        rxclk = 1'b0;
    logic        rstn = 1'b0;
    logic        emu_enable = 1'b0;
    logic        start = 1'b0;
    logic [15:0] baseline = '0, amp_a = '0, amp_b = '0, amp_c = '0;
    logic [31:0] pulse_width = '0, delay_ab = '0, delay_bc = '0;
    logic [31:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d;
    logic        adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d;
    logic        adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d;
    logic        busy, done;
    logic [31:0] expected_tof;

    pulse_emulator dut (
        .rxclk        (rxclk),
        .rstn         (rstn),
        .emu_enable   (emu_enable),
        .start        (start),
        .baseline     (baseline),
        .amp_a        (amp_a),
        .amp_b        (amp_b),
        .amp_c        (amp_c),
        .pulse_width  (pulse_width),
        .delay_ab     (delay_ab),
        .delay_bc     (delay_bc),
        .adc_data_a   (adc_data_a),
        .adc_data_b   (adc_data_b),
        .adc_data_c   (adc_data_c),
        .adc_data_d   (adc_data_d),
        .adc_valid_a  (adc_valid_a),
        .adc_valid_b  (adc_valid_b),
        .adc_valid_c  (adc_valid_c),
        .adc_valid_d  (adc_valid_d),
        .adc_enable_a (adc_enable_a),
        .adc_enable_b (adc_enable_b),
        .adc_enable_c (adc_enable_c),
        .adc_enable_d (adc_enable_d),
        .busy         (busy),
        .done         (done),
        .expected_tof (expected_tof)
    );

    always #4 rxclk = ~rxclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: a run is described by its start clock and latched parameters
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2;
    int          mode = M_IDLE;
    longint      cyc = 0, e0 = 0, mw = 1, mdab = 1, mdbc = 1;
    logic [15:0] m_base = '0, m_amp_a = '0, m_amp_b = '0, m_amp_c = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_tof = '0;
    int          dut_runs = 0;
    logic        prev_busy = 1'b0;

    function automatic logic [15:0] sat16(input logic [15:0] b, input logic [15:0] a);
        int s;
        s = int'($signed(b)) + int'($signed(a));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic model_reset();
        mode = M_IDLE;
        m_done = 1'b0;
        m_tof = '0;
        prev_busy = 1'b0;
    endtask

    task automatic model_edge();
        cyc++;
        if (!emu_enable) begin
            mode = M_IDLE;
            m_done = 1'b0;
        end else begin
            case (mode)
                M_IDLE: if (start) begin
                    mode = M_RUN;
                    e0 = cyc;
                    m_base = baseline;
                    m_amp_a = amp_a;
                    m_amp_b = amp_b;
                    m_amp_c = amp_c;
                    mw = (pulse_width == 0) ? 1 : longint'(pulse_width);
                    mdab = (longint'(delay_ab) < mw) ? mw : longint'(delay_ab);
                    mdbc = (longint'(delay_bc) < mw) ? mw : longint'(delay_bc);
                    m_done = 1'b0;
                    m_tof = delay_ab;
                    $display("run cyc=%0d base=%h amps=%h/%h/%h w=%0d dab=%0d dbc=%0d",
                             cyc, m_base, m_amp_a, m_amp_b, m_amp_c, mw, mdab, mdbc);
                end
                M_RUN: if (cyc - e0 >= mdab + mdbc + mw) begin
                    mode = M_WAIT;
                    m_done = 1'b1;
                end
                M_WAIT: if (!start) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        longint      rel;
        logic [15:0] base, ea, eb, ec;
        logic        run;
        run  = (mode == M_RUN);
        rel  = cyc - e0;
        base = run ? m_base : baseline;
        ea = (run && rel < mw) ? sat16(m_base, m_amp_a) : base;
        eb = (run && rel >= mdab && rel < mdab + mw) ? sat16(m_base, m_amp_b) : base;
        ec = (run && rel >= mdab + mdbc && rel < mdab + mdbc + mw) ? sat16(m_base, m_amp_c) : base;
        check("data_a", adc_data_a, {ea, ea});
        check("data_b", adc_data_b, {eb, eb});
        check("data_c", adc_data_c, {ec, ec});
        check("data_d", adc_data_d, {base, base});
        check("valid_enable", {24'd0, adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
                               adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d},
              {24'd0, {8{emu_enable}}});
        check("busy", {31'd0, busy}, {31'd0, run});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("tof", expected_tof, m_tof);
        if (busy && !prev_busy) dut_runs++;
        prev_busy = busy;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, adc_data_a, 32'h0);
        check({tag, "_b"}, adc_data_b, 32'h0);
        check({tag, "_c"}, adc_data_c, 32'h0);
        check({tag, "_d"}, adc_data_d, 32'h0);
        check({tag, "_flags"}, {22'd0, adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
                                adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d,
                                busy, done}, 32'h0);
        check({tag, "_tof"}, expected_tof, 32'h0);
    endtask

    task automatic step();
        @(posedge rxclk);
        model_edge();
        @(negedge rxclk);
        check_outputs();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic set_params(input logic [15:0] b, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [31:0] w, input logic [31:0] dab,
                              input logic [31:0] dbc);
        baseline = b;
        amp_a = a0;
        amp_b = a1;
        amp_c = a2;
        pulse_width = w;
        delay_ab = dab;
        delay_bc = dbc;
    endtask

    task automatic randomize_params();
        set_params(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 6), $urandom_range(0, 25), $urandom_range(0, 25));
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int runs0;

    initial begin
        #2 check_zero("reset");
        @(negedge rxclk);
        rstn = 1'b1;
        model_reset();
        emu_enable = 1'b1;

        // Basic run
        set_params(16'h0000, 16'h1000, 16'h1000, 16'h1000, 4, 100, 50);
        step();
        kick();
        check("basic_a_first", adc_data_a, 32'h10001000);
        run_cycles(99);
        check("basic_b_pre", adc_data_b, 32'h00000000);
        step();
        check("basic_b_first", adc_data_b, 32'h10001000);
        run_cycles(53);
        check("basic_c_last", adc_data_c, 32'h10001000);
        step();
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_tof", expected_tof, 32'd100);
        run_cycles(3);

        // Saturation high and low
        set_params(16'h7000, 16'h2000, 16'h0000, 16'h0000, 3, 5, 5);
        kick();
        check("sat_hi_a", adc_data_a, 32'h7FFF7FFF);
        check("sat_hi_d", adc_data_d, 32'h70007000);
        run_cycles(20);
        set_params(16'h9000, 16'h0000, 16'hE000, 16'h0000, 3, 5, 5);
        kick();
        run_cycles(5);
        check("sat_lo_b", adc_data_b, 32'h80008000);
        check("sat_lo_d", adc_data_d, 32'h90009000);
        run_cycles(20);

        // Clamping of zero width and short delays
        set_params(16'h0100, 16'h0010, 16'h0020, 16'h0030, 0, 0, 2);
        kick();
        check("clamp_a", adc_data_a, 32'h01100110);
        step();
        check("clamp_b", adc_data_b, 32'h01200120);
        check("clamp_a_end", adc_data_a, 32'h01000100);
        step();
        check("clamp_c_gap", adc_data_c, 32'h01000100);
        step();
        check("clamp_c", adc_data_c, 32'h01300130);
        step();
        check("clamp_done", {31'd0, done}, 32'd1);
        run_cycles(5);

        // Abort during the A-B gap, then a full run
        set_params(16'h0000, 16'h1000, 16'h1000, 16'h1000, 4, 100, 50);
        kick();
        run_cycles(20);
        emu_enable = 1'b0;
        step();
        check("abort_flags", {29'd0, busy, done, adc_valid_a}, 32'd0);
        emu_enable = 1'b1;
        run_cycles(120);
        kick();
        run_cycles(160);
        check("rerun_done", {31'd0, done}, 32'd1);

        // start held high for a whole run gives exactly one sequence
        set_params(16'h0050, 16'h0001, 16'h0002, 16'h0003, 3, 10, 10);
        runs0 = dut_runs;
        start = 1'b1;
        run_cycles(200);
        check("single_seq", 32'(dut_runs - runs0), 32'd1);
        start = 1'b0;
        step();
        kick();
        check("retrigger", 32'(dut_runs - runs0), 32'd2);
        run_cycles(40);

        // Inputs scrambled mid-run must not disturb the latched run
        set_params(16'h0000, 16'h0100, 16'h0200, 16'h0300, 5, 30, 20);
        kick();
        repeat (70) begin
            randomize_params();
            step();
        end
        check("shadow_tof", expected_tof, 32'd30);

        // Asynchronous reset while channel b is pulsing
        set_params(16'h0200, 16'h0040, 16'h0080, 16'h00C0, 4, 10, 10);
        kick();
        run_cycles(10);
        check("prereset_b", adc_data_b, 32'h02800280);
        #2 rstn = 1'b0;
        #1 check_zero("rst_mid");
        model_reset();
        @(negedge rxclk);
        check_zero("rst_hold");
        rstn = 1'b1;
        run_cycles(30);
        kick();
        run_cycles(40);

        // Randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) start = ~start;
            emu_enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) randomize_params();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
